// File: rtl/ap_hs_arb_pkg.sv
// Purpose: shared types, defaults and the round-robin pick function for ap_hs_arbiter.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t    - arbiter FSM encoding (IDLE, START, RUN, DONE)
//   CNT_W_DEFAULT  - default width of the optional performance counters
//   MAX_REQ        - largest supported requester count; the pick function works on this width
//   rr_pick()      - first set request at or after a pointer, wrapping; -1 when none is set
package ap_hs_arb_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int MAX_REQ       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Scans offsets from the highest down to zero and overwrites on every hit,
  // so the surviving pick is the smallest offset from ptr. This keeps the
  // loop free of early exits, which maps to a plain priority mux.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int                 ptr,
                                 input int                 n);
    int pick;
    int idx;
    pick = -1;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[2:0]]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: round-robin winner selection among NUM_REQ request lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is only consumed while the arbiter is idle.
//
// Ports:
//   i_req    [NUM_REQ] - request vector
//   i_ptr    [ID_W]    - highest-priority index for this pick
//   o_winner [ID_W]    - selected index (0 when nothing is requested)
//   o_valid            - at least one request is set
module rr_picker
  import ap_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_req_pad;
  int                 w_pick;

  always_comb begin
    w_req_pad                = '0;
    w_req_pad[NUM_REQ-1:0]   = i_req;
    w_pick                   = rr_pick(w_req_pad, int'(i_ptr), NUM_REQ);
    o_valid                  = (w_pick >= 0);
    o_winner                 = o_valid ? ID_W'(w_pick) : '0;
  end

endmodule

// File: rtl/ap_hs_arbiter.sv
// Purpose: shares one ap_ctrl_hs callee between NUM_REQ ap_ctrl_hs requesters, round-robin, one owner per transaction.
// Latency: request seen in IDLE -> grp_ap_start next cycle; grp_ap_done -> req_ap_done next cycle; ready is passed through same cycle.
// Backpressure: requesters hold req_ap_start until their req_ap_ready; the callee stalls the arbiter by withholding grp_ap_ready/grp_ap_done.
//
// Ports:
//   ap_clk, ap_rst_n        - clock, asynchronous active-low reset (shared with the callee)
//   req_ap_start [NUM_REQ]  - per-requester start, held until the matching ready pulse
//   req_ap_ready [NUM_REQ]  - one-cycle pulse to the owner when the callee accepts its start
//   req_ap_done  [NUM_REQ]  - one-cycle pulse to the owner when its transaction finishes
//   grp_ap_start            - start to the shared callee
//   grp_ap_ready/done       - callee handshake returns
//   grant_id [ID_W]         - current owner, meaningful while busy
//   busy                    - arbiter is not idle
// Optional: define AP_HS_ARB_PERF_EN to add saturating perf_served/perf_wait counters per requester.
module ap_hs_arbiter
  import ap_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_REQ-1:0] req_ap_start,
  output logic [NUM_REQ-1:0] req_ap_ready,
  output logic [NUM_REQ-1:0] req_ap_done,
  output logic               grp_ap_start,
  input  logic               grp_ap_ready,
  input  logic               grp_ap_done,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
`ifdef AP_HS_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_served [NUM_REQ],
  output logic [CNT_W-1:0]   perf_wait   [NUM_REQ]
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || CNT_W < 1) begin : g_bad_cfg
    $error("ap_hs_arbiter: NUM_REQ must be 2..8 and CNT_W at least 1");
  end

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    w_grant_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_rr_ptr_nxt;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_pick_vld;
  logic [NUM_REQ-1:0] w_grant_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .i_req    (req_ap_start),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_pick_id),
    .o_valid  (w_pick_vld)
  );

  // Pulses are steered only through this decode of the registered owner,
  // so no other index can ever see a ready or done.
  always_comb begin
    w_grant_oh             = '0;
    w_grant_oh[r_grant_id] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant_id;
    w_rr_ptr_nxt = r_rr_ptr;
    grp_ap_start = 1'b0;
    req_ap_ready = '0;
    req_ap_done  = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_id;
          w_state_nxt = START;
        end
      end

      START: begin
        grp_ap_start = 1'b1;
        // A done without the matching ready is not a valid callee response
        // here, so it only counts together with ready.
        if (grp_ap_ready) begin
          req_ap_ready = w_grant_oh;
          w_state_nxt  = grp_ap_done ? DONE : RUN;
        end
      end

      RUN: begin
        if (grp_ap_done) begin
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        req_ap_done  = w_grant_oh;
        w_rr_ptr_nxt = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        w_state_nxt  = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

`ifdef AP_HS_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic             w_owner;
    logic [CNT_W-1:0] r_served;
    logic [CNT_W-1:0] r_wait;

    // Ownership covers START, RUN and DONE; any other cycle with start
    // raised is time spent waiting for the callee.
    assign w_owner = busy && (r_grant_id == ID_W'(gi));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_served <= '0;
        r_wait   <= '0;
      end else begin
        if (req_ap_done[gi] && (r_served != '1)) begin
          r_served <= r_served + 1'b1;
        end
        if (req_ap_start[gi] && !w_owner && (r_wait != '1)) begin
          r_wait <= r_wait + 1'b1;
        end
      end
    end

    assign perf_served[gi] = r_served;
    assign perf_wait[gi]   = r_wait;
  end
`endif

endmodule

// File: tb/tb_ap_hs_arbiter.sv
// Purpose: self-checking bench for ap_hs_arbiter with a pulse scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked before the falling edge.
// Backpressure: the bench plays the callee and releases ready/done on scripted delays.
module tb_ap_hs_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int CNT_W   = 16;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic [NUM_REQ-1:0] req_ap_start;
  logic [NUM_REQ-1:0] req_ap_ready;
  logic [NUM_REQ-1:0] req_ap_done;
  logic               grp_ap_start;
  logic               grp_ap_ready;
  logic               grp_ap_done;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
`ifdef AP_HS_ARB_PERF_EN
  logic [CNT_W-1:0]   perf_served [NUM_REQ];
  logic [CNT_W-1:0]   perf_wait   [NUM_REQ];
`endif

  int checks        = 0;
  int errors        = 0;
  int cycle         = 0;
  int cur_owner     = -1;
  int last_done_cyc = -1;
  int rem      [NUM_REQ];
  int exp_wait [NUM_REQ];
  int exp_ready_q [$];
  int exp_done_q  [$];

  always #5 ap_clk = ~ap_clk;

  ap_hs_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .req_ap_start (req_ap_start),
    .req_ap_ready (req_ap_ready),
    .req_ap_done  (req_ap_done),
    .grp_ap_start (grp_ap_start),
    .grp_ap_ready (grp_ap_ready),
    .grp_ap_done  (grp_ap_done),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef AP_HS_ARB_PERF_EN
    ,
    .perf_served  (perf_served),
    .perf_wait    (perf_wait)
`endif
  );

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (i >= 0 && i < NUM_REQ) v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every pulse the DUT emits must match the next expected owner.
  always @(negedge ap_clk) begin
    int e;
    if (req_ap_ready !== '0) begin
      checks++;
      if (exp_ready_q.size() == 0) begin
        errors++;
        $display("FAIL sb_ready: unexpected req_ap_ready=%b at cycle %0d, none required", req_ap_ready, cycle);
      end else begin
        e = exp_ready_q.pop_front();
        if (req_ap_ready !== oh(e)) begin
          errors++;
          $display("FAIL sb_ready: req_ap_ready=%b, required %b", req_ap_ready, oh(e));
        end
      end
    end
    if (req_ap_done !== '0) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL sb_done: unexpected req_ap_done=%b at cycle %0d, none required", req_ap_done, cycle);
      end else begin
        e = exp_done_q.pop_front();
        if (req_ap_done !== oh(e)) begin
          errors++;
          $display("FAIL sb_done: req_ap_done=%b, required %b", req_ap_done, oh(e));
        end
      end
    end
  end

  // Counts the cycle that is about to end as a wait cycle where applicable, then advances.
  task automatic next_cycle();
    if (ap_rst_n === 1'b1) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ap_start[i] && cur_owner != i) exp_wait[i]++;
      end
    end
    @(posedge ap_clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    ap_rst_n     = 1'b0;
    req_ap_start = '0;
    grp_ap_ready = 1'b0;
    grp_ap_done  = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n      = 1'b1;
    cur_owner     = -1;
    last_done_cyc = -1;
    cycle         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      exp_wait[i] = 0;
      rem[i]      = 0;
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_ready_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: %0d ready and %0d done pulses still owed, required 0", name,
               exp_ready_q.size(), exp_done_q.size());
    end
    exp_ready_q.delete();
    exp_done_q.delete();
  endtask

  // Plays the callee for one transaction: waits for grp_ap_start, raises ready
  // rdy_dly cycles into START, and done done_dly cycles after ready.
  task automatic run_txn(input int exp_owner, input int rdy_dly, input int done_dly);
    int n;
    n = 0;
    while (grp_ap_start !== 1'b1 && n < 40) begin
      next_cycle();
      n++;
    end
    checks++;
    if (grp_ap_start !== 1'b1) begin
      errors++;
      $display("FAIL txn_start_timeout: grp_ap_start=%b after %0d cycles, required 1", grp_ap_start, n);
      return;
    end
    checks++;
    if (grant_id !== ID_W'(exp_owner)) begin
      errors++;
      $display("FAIL txn_grant_id: grant_id=%0d, required %0d", grant_id, exp_owner);
    end
    if (last_done_cyc >= 0) begin
      checks++;
      if (cycle - last_done_cyc < 3) begin
        errors++;
        $display("FAIL txn_gap: next start %0d cycles after done, required at least 3", cycle - last_done_cyc);
      end
    end
    cur_owner = exp_owner;
    repeat (rdy_dly) next_cycle();
    grp_ap_ready = 1'b1;
    exp_ready_q.push_back(exp_owner);
    if (done_dly == 0) begin
      grp_ap_done = 1'b1;
      exp_done_q.push_back(exp_owner);
      last_done_cyc = cycle;
    end
    #1;
    checks++;
    if (req_ap_ready !== oh(exp_owner)) begin
      errors++;
      $display("FAIL txn_ready_passthru: req_ap_ready=%b, required %b", req_ap_ready, oh(exp_owner));
    end
    next_cycle();
    grp_ap_ready = 1'b0;
    grp_ap_done  = 1'b0;
    rem[exp_owner]--;
    if (rem[exp_owner] <= 0) req_ap_start[exp_owner] = 1'b0;
    if (done_dly > 0) begin
      repeat (done_dly - 1) next_cycle();
      grp_ap_done = 1'b1;
      exp_done_q.push_back(exp_owner);
      last_done_cyc = cycle;
      next_cycle();
      grp_ap_done = 1'b0;
    end
    #1;
    checks++;
    if (req_ap_done !== oh(exp_owner) || busy !== 1'b1) begin
      errors++;
      $display("FAIL txn_done_pulse: req_ap_done=%b busy=%b, required %b busy=1", req_ap_done, busy, oh(exp_owner));
    end
    next_cycle();
    cur_owner = -1;
  endtask

  task automatic test_reset();
    ap_rst_n     = 1'b0;
    req_ap_start = '1;
    grp_ap_ready = 1'b1;
    grp_ap_done  = 1'b1;
    #2;
    checks++;
    if ({busy, grp_ap_start, grant_id, req_ap_ready, req_ap_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b start=%b grant=%0d ready=%b done=%b, required all 0",
               busy, grp_ap_start, grant_id, req_ap_ready, req_ap_done);
    end
`ifdef AP_HS_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (perf_served[i] !== '0 || perf_wait[i] !== '0) begin
        errors++;
        $display("FAIL reset_perf[%0d]: served=%0d wait=%0d, required 0", i, perf_served[i], perf_wait[i]);
      end
    end
`endif
    repeat (2) @(posedge ap_clk);
    #1;
    req_ap_start = '0;
    grp_ap_ready = 1'b0;
    grp_ap_done  = 1'b0;
    ap_rst_n     = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single();
    logic exp;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      req_ap_start[0] = (c <= 3);
      grp_ap_ready    = (c == 3);
      grp_ap_done     = (c == 10);
      if (c == 3)  exp_ready_q.push_back(0);
      if (c == 10) exp_done_q.push_back(0);
      #1;
      exp = (c >= 1 && c <= 3);
      checks++;
      if (grp_ap_start !== exp) begin
        errors++;
        $display("FAIL single_grp_start c=%0d: got %b, required %b", c, grp_ap_start, exp);
      end
      exp = (c >= 1 && c <= 11);
      checks++;
      if (busy !== exp) begin
        errors++;
        $display("FAIL single_busy c=%0d: got %b, required %b", c, busy, exp);
      end
      exp = (c == 3);
      checks++;
      if (req_ap_ready[0] !== exp) begin
        errors++;
        $display("FAIL single_ready c=%0d: got %b, required %b", c, req_ap_ready[0], exp);
      end
      exp = (c == 11);
      checks++;
      if (req_ap_done[0] !== exp) begin
        errors++;
        $display("FAIL single_done c=%0d: got %b, required %b", c, req_ap_done[0], exp);
      end
      next_cycle();
    end
    check_sb_empty("single");
  endtask

  task automatic test_contention();
    do_reset();
    rem[0] = 2;
    rem[1] = 2;
    req_ap_start = '1;
    run_txn(0, 1, 3);
    run_txn(1, 0, 2);
    run_txn(0, 2, 0);
    run_txn(1, 0, 4);
    next_cycle();
    next_cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle: busy=%b, required 0", busy);
    end
`ifdef AP_HS_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (perf_served[i] !== CNT_W'(2)) begin
        errors++;
        $display("FAIL perf_served[%0d]: got %0d, required 2", i, perf_served[i]);
      end
      checks++;
      if (perf_wait[i] !== CNT_W'(exp_wait[i])) begin
        errors++;
        $display("FAIL perf_wait[%0d]: got %0d, required %0d", i, perf_wait[i], exp_wait[i]);
      end
    end
`endif
    check_sb_empty("contention");
  endtask

  task automatic test_ready_done_same();
    do_reset();
    rem[0] = 1;
    req_ap_start[0] = 1'b1;
    run_txn(0, 0, 0);
    checks++;
    if (busy !== 1'b0 || grp_ap_start !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_idle: busy=%b start=%b, required 0 0", busy, grp_ap_start);
    end
    check_sb_empty("same_cycle");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req_ap_start[0] = 1'b1;
    next_cycle();
    grp_ap_ready = 1'b1;
    exp_ready_q.push_back(0);
    next_cycle();
    grp_ap_ready    = 1'b0;
    req_ap_start[0] = 1'b0;
    req_ap_start[1] = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || grp_ap_start !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL midrun_run_state: busy=%b start=%b grant=%0d, required 1 0 0", busy, grp_ap_start, grant_id);
    end
    next_cycle();
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, grp_ap_start, grant_id, req_ap_ready, req_ap_done} !== '0) begin
      errors++;
      $display("FAIL midrun_async_reset: busy=%b start=%b grant=%0d ready=%b done=%b, required all 0",
               busy, grp_ap_start, grant_id, req_ap_ready, req_ap_done);
    end
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    cur_owner = -1;
    rem[1]    = 1;
    last_done_cyc = -1;
    run_txn(1, 1, 2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_final_idle: busy=%b, required 0", busy);
    end
    check_sb_empty("midrun");
  endtask

  task automatic test_withdrawal();
    do_reset();
    req_ap_start[0] = 1'b1;
    next_cycle();
    grp_ap_ready = 1'b1;
    exp_ready_q.push_back(0);
    next_cycle();
    // RUN: stray callee ready plus a one-cycle blip from requester 1
    grp_ap_ready    = 1'b1;
    req_ap_start[0] = 1'b0;
    req_ap_start[1] = 1'b1;
    #1;
    checks++;
    if (req_ap_ready !== '0) begin
      errors++;
      $display("FAIL withdraw_run_ready_ignored: req_ap_ready=%b, required 00", req_ap_ready);
    end
    next_cycle();
    grp_ap_ready    = 1'b0;
    req_ap_start[1] = 1'b0;
    next_cycle();
    grp_ap_done = 1'b1;
    exp_done_q.push_back(0);
    next_cycle();
    grp_ap_done = 1'b0;
    #1;
    checks++;
    if (req_ap_done !== oh(0)) begin
      errors++;
      $display("FAIL withdraw_done0: req_ap_done=%b, required %b", req_ap_done, oh(0));
    end
    next_cycle();
    grp_ap_ready = 1'b1;
    grp_ap_done  = 1'b1;
    #1;
    checks++;
    if (req_ap_ready !== '0 || req_ap_done !== '0) begin
      errors++;
      $display("FAIL withdraw_idle_stray: ready=%b done=%b, required 00 00", req_ap_ready, req_ap_done);
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      grp_ap_ready = 1'b0;
      grp_ap_done  = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL withdraw_not_granted k=%0d: busy=%b grant=%0d, required busy 0", k, busy, grant_id);
      end
    end
    check_sb_empty("withdraw");
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    req_ap_start = '0;
    grp_ap_ready = 1'b0;
    grp_ap_done  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_ready_done_same();
    test_reset_mid_run();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_hs_arbiter.md
Name: ap_hs_arbiter

Overview:
Shares one ap_ctrl_hs callee, for example a pipelined loop sub-module such as a VITIS_LOOP grp instance, between NUM_REQ requesters that each use an ap_ctrl_hs handshake.
- Round-robin arbitration: exactly one requester owns the callee per transaction, from start to done.
- Sits between the top-level FSM call sites and the shared grp_* instance.
- Returns per-requester ap_ready and ap_done pulses so that existing handshake monitors still observe each requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
ID_W, $clog2(NUM_REQ) (minimum 1), width of grant_id.
CNT_W, 16, width of the optional performance counters.

Ports:
ap_clk  in  1  clock; all state updates on the rising edge.
ap_rst_n  in  1  asynchronous, active-low reset.
req_ap_start  in  NUM_REQ  per-requester start; held high until the matching req_ap_ready.
req_ap_ready  out  NUM_REQ  one-cycle pulse: the callee accepted this requester's start.
req_ap_done  out  NUM_REQ  one-cycle pulse: this requester's transaction finished.
grp_ap_start  out  1  start to the callee.
grp_ap_ready  in  1  callee ready (inputs consumed).
grp_ap_done  in  1  callee done.
grant_id  out  ID_W  index of the current owner; valid while busy=1.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0.
- Reset is asynchronous. Asserting it mid-operation forces IDLE immediately and drops grp_ap_start and all pulses. No done is issued for the aborted transaction. The callee shares the same reset.
- FSM states and transitions:
  - IDLE: if any req_ap_start is high, take the winner = first requester high scanning from rr_ptr upward with wrap. Register grant_id=winner and go to START. The selection is combinational; the grant becomes visible on the next cycle.
  - START: grp_ap_start=1 (combinational from state). When grp_ap_ready=1, pulse req_ap_ready[grant_id] in that same cycle (combinational pass-through). Next state is RUN, or DONE if grp_ap_done=1 in the same cycle.
  - RUN: grp_ap_start=0. When grp_ap_done=1, go to DONE.
  - DONE: req_ap_done[grant_id]=1 for exactly this one cycle. rr_ptr=(grant_id+1) mod NUM_REQ. Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 → grp_ap_start high at cycle 1.
  - grp_ap_done at cycle t → req_ap_done at cycle t+1.
  - Back-to-back transactions: the next grp_ap_start occurs at t+3 or later.
- Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
- Withdrawal before grant: a requester that drops req_ap_start is not tracked (no state is kept).
- Deassertion after grant: req_ap_start falling after the grant is ignored. The transaction completes and req_ap_done is still issued.
- Callee signals outside the expected states are ignored and produce no pulses: grp_ap_ready/grp_ap_done in IDLE or DONE, and grp_ap_ready in RUN.
- Pulse guarantees:
  - Only the granted index ever pulses.
  - req_ap_ready and req_ap_done are each one-hot-or-zero.

Optional Feature:
Macro AP_HS_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_served[NUM_REQ][CNT_W]: incremented on each req_ap_done pulse.
  - Adds outputs perf_wait[NUM_REQ][CNT_W]: incremented on every cycle where req_ap_start[i]=1 and requester i is not the owner in START/RUN/DONE.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: no counters, no extra ports, identical cycle behaviour.

Decomposition:
- Package ap_hs_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, RUN, DONE} arb_state_t;
  - a round-robin pick function;
  - a localparam for the default CNT_W.
- Sub-module rr_picker: combinational. Inputs are request vector and rr_ptr; outputs are winner index and valid.

Test Plan:
- Single requester: req0 start at cycle 0; callee ready at cycle 3, done at cycle 10 → grp_ap_start high cycles 1–3; req_ap_ready[0] at cycle 3; req_ap_done[0] at cycle 11; busy low at cycle 12.
- Contention: req0 and req1 both start at cycle 0 and stay high → grant order 0,1,0,1; grp_ap_start never overlaps; done pulses alternate.
- Same-cycle ready+done: callee asserts ready and done together in START → ready pulse that cycle, done pulse next cycle, RUN skipped.
- Reset mid-RUN: drive ap_rst_n=0 between ready and done → outputs go to 0 immediately; no req_ap_done; after release, a pending req1 is granted first because rr_ptr=0 scans 0 then 1, with req0 idle.
- Withdrawal: req1 pulses start for one cycle while req0 owns the callee → req1 never granted; no req_ap_ready[1] or req_ap_done[1].
- With AP_HS_ARB_PERF_EN defined: the contention test for 4 transactions → perf_served={2,2}; perf_wait[1] equals the cycles req1 spent waiting, checked against the scoreboard.
